// File: rtl/cla_nibble_serial_adder.sv
// Nibble-serial WIDTH-bit adder built around a 4-bit carry-lookahead slice.
// Operands are accepted on one handshake, summed LSB nibble first, and returned on a second handshake.

module cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] so,
    output logic       co
);
    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    // Carries come from flattened generate/propagate terms, not a ripple chain.
    always_comb begin
        p    = a ^ b;
        g    = a & b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        so   = p ^ c[3:0];
        co   = c[4];
    end
endmodule

module cla_nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [3:0]         cla_a;
    logic [3:0]         cla_b;
    logic [3:0]         cla_so;
    logic               cla_co;

    assign cla_a = a_q[4*idx_q +: 4];
    assign cla_b = b_q[4*idx_q +: 4];

    cla4 u_cla (
        .a   (cla_a),
        .b   (cla_b),
        .cin (carry_q),
        .so  (cla_so),
        .co  (cla_co)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[4*idx_q +: 4] = cla_so;
                carry_d             = cla_co;
                if (idx_q == LAST_IDX) begin
                    cout_d  = cla_co;
                    // Last nibble's top bit is the sum MSB being written this edge.
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (cla_so[3] != a_q[WIDTH-1]);
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Operand registers are only meaningful after an accept, so they carry no reset.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;
endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// Directed bench for cla_nibble_serial_adder at WIDTH=16.
module tb_cla_nibble_serial_adder;
    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    int n_total = 0;
    int n_bad   = 0;

    cla_nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept, run, check latency and result; leaves the block in DONE.
    task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic cv, input logic junk_valid,
                          input logic [15:0] es, input logic ec, input logic eo);
        a        = av;
        b        = bv;
        cin      = cv;
        in_valid = 1'b1;
        chk({tag, ".ready_pre"}, 32'(in_ready), 32'd1);
        tick();
        // junk_valid keeps in_valid high with different operands during RUN
        if (junk_valid) begin
            a   = ~av;
            b   = ~bv;
            cin = ~cv;
        end else begin
            in_valid = 1'b0;
        end
        chk({tag, ".ready_run"}, 32'(in_ready), 32'd0);
        for (int i = 1; i < NIB; i++) begin
            tick();
            chk({tag, ".vld_early"}, 32'(out_valid), 32'd0);
        end
        tick();
        in_valid = 1'b0;
        chk({tag, ".vld"},   32'(out_valid), 32'd1);
        chk({tag, ".ready"}, 32'(in_ready),  32'd0);
        chk({tag, ".sum"},   32'(sum),       32'(es));
        chk({tag, ".cout"},  32'(cout),      32'(ec));
        chk({tag, ".ovf"},   32'(overflow),  32'(eo));
    endtask

    task automatic take_result(input string tag, input logic [15:0] es);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, ".idle_ready"}, 32'(in_ready),  32'd1);
        chk({tag, ".idle_vld"},   32'(out_valid), 32'd0);
        chk({tag, ".sum_held"},   32'(sum),       32'(es));
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst.ready", 32'(in_ready),  32'd1);
        chk("rst.vld",   32'(out_valid), 32'd0);
        chk("rst.sum",   32'(sum),       32'd0);
        chk("rst.cout",  32'(cout),      32'd0);
        chk("rst.ovf",   32'(overflow),  32'd0);

        // idle with in_valid low stays idle
        tick();
        chk("idle.ready", 32'(in_ready), 32'd1);

        run_op("t1", 16'h0001, 16'h0007, 1'b1, 1'b0, 16'h0009, 1'b0, 1'b0);
        take_result("t1", 16'h0009);

        run_op("t2", 16'hFFFF, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);
        take_result("t2", 16'h0000);

        run_op("t3a", 16'h5A5A, 16'hA5A5, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0);
        take_result("t3a", 16'hFFFF);
        run_op("t3b", 16'h5A5A, 16'hA5A5, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        take_result("t3b", 16'h0000);
        run_op("t3c", 16'h5A5A, 16'hA5A5, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0);

        // backpressure: hold DONE while offering new operands
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a        = 16'h1234 + 16'(i);
            b        = 16'h4321;
            cin      = i[0];
            tick();
            in_valid = 1'b0;
            chk("t4.vld",   32'(out_valid), 32'd1);
            chk("t4.ready", 32'(in_ready),  32'd0);
            chk("t4.sum",   32'(sum),       32'hFFFF);
            chk("t4.cout",  32'(cout),      32'd0);
        end
        take_result("t4", 16'hFFFF);
        tick();
        chk("t4.no_capture", 32'(in_ready), 32'd1);

        // reset mid-run after two RUN edges
        a        = 16'h0FFF;
        b        = 16'h0001;
        cin      = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("t5.midrun_vld", 32'(out_valid), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5.ready", 32'(in_ready),  32'd1);
        chk("t5.vld",   32'(out_valid), 32'd0);
        chk("t5.sum",   32'(sum),       32'd0);
        chk("t5.cout",  32'(cout),      32'd0);
        run_op("t5b", 16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0);
        take_result("t5b", 16'h0007);

        run_op("t6a", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        take_result("t6a", 16'h8000);
        run_op("t6b", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

        // reset during DONE handshake
        out_ready = 1'b1;
        rst       = 1'b1;
        tick();
        rst       = 1'b0;
        out_ready = 1'b0;
        chk("t7.ready", 32'(in_ready),  32'd1);
        chk("t7.ovf",   32'(overflow),  32'd0);
        chk("t7.cout",  32'(cout),      32'd0);

        run_op("t8", 16'h1F3C, 16'h20E5, 1'b1, 1'b0, 16'h4022, 1'b0, 1'b0);
        take_result("t8", 16'h4022);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
